// File: rtl/opdecoder.sv
// ----------------------------------------------------------------------------
// opdecoder
//   RV64 major-opcode decoder for the decode stage. Turns instruction[6:0] into
//   a 32-bit one-hot code indexed by opcode[6:2] and an instruction-format
//   one-hot. Both are available combinationally. A registered copy of each
//   output feeds the next pipeline stage.
//
//   Optional feature: define OPDECODER_ILLEGAL_EN to drive illegal/illegal_q.
//   With the macro defined, non-32-bit encodings and the custom, reserved and
//   longer-than-32-bit indices are flagged. Without it, both illegal outputs
//   stay at 0.
//
// Ports
//   clk        in   1   clock; the registered outputs update on the rising edge
//   rst_n      in   1   asynchronous active-low reset (clears *_q only)
//   opcode     in   7   instruction[6:0]
//   code       out  32  one-hot, bit opcode[6:2] set (0 for non-32-bit)
//   fmt        out  7   format one-hot {r4,uj,u,sb,s,i,r}
//   illegal    out  1   illegal/unsupported opcode
//   code_q     out  32  registered code
//   fmt_q      out  7   registered fmt
//   illegal_q  out  1   registered illegal
// ----------------------------------------------------------------------------
module opdecoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    output logic [31:0] code,
    output logic [6:0]  fmt,
    output logic        illegal,
    output logic [31:0] code_q,
    output logic [6:0]  fmt_q,
    output logic        illegal_q
);

    localparam logic [6:0] FMT_R  = 7'b0000001;
    localparam logic [6:0] FMT_I  = 7'b0000010;
    localparam logic [6:0] FMT_S  = 7'b0000100;
    localparam logic [6:0] FMT_SB = 7'b0001000;
    localparam logic [6:0] FMT_U  = 7'b0010000;
    localparam logic [6:0] FMT_UJ = 7'b0100000;
    localparam logic [6:0] FMT_R4 = 7'b1000000;

    logic [4:0] idx;
    logic       is32;

    assign idx  = opcode[6:2];
    assign is32 = (opcode[1:0] == 2'b11);

    always_comb begin
        code = '0;
        fmt  = '0;
        if (is32) begin
            code = 32'd1 << idx;
            case (idx)
                5'd0, 5'd1, 5'd3, 5'd4,
                5'd6, 5'd25, 5'd28:          fmt = FMT_I;
                5'd5, 5'd13:                 fmt = FMT_U;
                5'd8, 5'd9:                  fmt = FMT_S;
                5'd11, 5'd12, 5'd14, 5'd20:  fmt = FMT_R;
                5'd16, 5'd17, 5'd18, 5'd19:  fmt = FMT_R4;
                5'd24:                       fmt = FMT_SB;
                5'd27:                       fmt = FMT_UJ;
                default:                     fmt = '0;
            endcase
        end
    end

`ifdef OPDECODER_ILLEGAL_EN
    logic reserved;

    // Custom-0..3, reserved slots and the 48/64-bit escape encodings.
    always_comb begin
        reserved = 1'b0;
        case (idx)
            5'd2, 5'd7, 5'd10, 5'd15, 5'd21, 5'd22,
            5'd23, 5'd26, 5'd29, 5'd30, 5'd31: reserved = 1'b1;
            default:                           reserved = 1'b0;
        endcase
    end

    assign illegal = !is32 || reserved;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q    <= '0;
            fmt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            code_q    <= code;
            fmt_q     <= fmt;
            illegal_q <= illegal;
        end
    end

endmodule

// File: tb/tb_opdecoder.sv
// ----------------------------------------------------------------------------
// tb_opdecoder
//   Bench for opdecoder. The reference model works from the opcode tables:
//   index lists for each format and the list of supported indices.
// ----------------------------------------------------------------------------
module tb_opdecoder;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [31:0] code;
    logic [6:0]  fmt;
    logic        illegal;
    logic [31:0] code_q;
    logic [6:0]  fmt_q;
    logic        illegal_q;

    int errors = 0;
    int checks = 0;

    opdecoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .code      (code),
        .fmt       (fmt),
        .illegal   (illegal),
        .code_q    (code_q),
        .fmt_q     (fmt_q),
        .illegal_q (illegal_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int listed[21] = '{0, 1, 3, 4, 5, 6, 8, 9, 11, 12, 13, 14, 16, 17, 18, 19, 20, 24, 25, 27, 28};
    int set_i[7]   = '{0, 1, 3, 4, 6, 25, 28};
    int set_u[2]   = '{5, 13};
    int set_s[2]   = '{8, 9};
    int set_r[4]   = '{11, 12, 14, 20};
    int set_r4[4]  = '{16, 17, 18, 19};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int op_index(input logic [6:0] op);
        return int'(op) / 4;
    endfunction

    function automatic bit is_32bit(input logic [6:0] op);
        return (int'(op) % 4) == 3;
    endfunction

    function automatic logic [31:0] model_code(input logic [6:0] op);
        if (!is_32bit(op)) return 32'd0;
        return 32'(2 ** op_index(op));
    endfunction

    // Format bit positions: r=0, i=1, s=2, sb=3, u=4, uj=5, r4=6
    function automatic logic [6:0] model_fmt(input logic [6:0] op);
        int n;
        int bitpos;
        if (!is_32bit(op)) return 7'd0;
        n = op_index(op);
        bitpos = -1;
        foreach (set_r[k])  if (set_r[k] == n)  bitpos = 0;
        foreach (set_i[k])  if (set_i[k] == n)  bitpos = 1;
        foreach (set_s[k])  if (set_s[k] == n)  bitpos = 2;
        if (n == 24) bitpos = 3;
        foreach (set_u[k])  if (set_u[k] == n)  bitpos = 4;
        if (n == 27) bitpos = 5;
        foreach (set_r4[k]) if (set_r4[k] == n) bitpos = 6;
        if (bitpos < 0) return 7'd0;
        return 7'(2 ** bitpos);
    endfunction

    function automatic logic model_illegal(input logic [6:0] op);
`ifdef OPDECODER_ILLEGAL_EN
        bit found;
        if (!is_32bit(op)) return 1'b1;
        found = 1'b0;
        foreach (listed[k]) if (listed[k] == op_index(op)) found = 1'b1;
        return !found;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_comb(input string tag, input logic [6:0] op);
        check({tag, ".code"},    code,             model_code(op));
        check({tag, ".fmt"},     32'(fmt),         32'(model_fmt(op)));
        check({tag, ".illegal"}, 32'(illegal),     32'(model_illegal(op)));
    endtask

    task automatic check_regs(input string tag, input logic [6:0] op);
        check({tag, ".code_q"},    code_q,          model_code(op));
        check({tag, ".fmt_q"},     32'(fmt_q),      32'(model_fmt(op)));
        check({tag, ".illegal_q"}, 32'(illegal_q),  32'(model_illegal(op)));
    endtask

    initial begin
        logic [6:0] op;

        rst_n  = 1'b0;
        opcode = 7'b0000011;
        #2;
        check("rst.code_q",    code_q,         32'd0);
        check("rst.fmt_q",     32'(fmt_q),     32'd0);
        check("rst.illegal_q", 32'(illegal_q), 32'd0);
        // Combinational path is not affected by reset
        check("rst.code",      code,           32'h0000_0001);
        check("rst.fmt",       32'(fmt),       32'h02);
        @(posedge clk); #1;
        check("rst_held.code_q", code_q, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("load.comb.code", code, 32'h0000_0001);
        check("load.comb.fmt",  32'(fmt), 32'h02);
        check("load.comb.ill",  32'(illegal), 32'd0);
        check("prerel.code_q",  code_q, 32'd0);
        @(posedge clk); #1;
        check_regs("load", 7'b0000011);

        // Every listed index
        foreach (listed[k]) begin
            @(negedge clk);
            op = 7'((listed[k] * 4) + 3);
            opcode = op;
            #1;
            check_comb($sformatf("sweep%0d", listed[k]), op);
            @(posedge clk); #1;
            check_regs($sformatf("sweep%0d", listed[k]), op);
        end

        // JAL
        @(negedge clk);
        opcode = 7'b1101111;
        #1;
        check("jal.code", code, 32'h0800_0000);
        check("jal.fmt",  32'(fmt), 32'h20);
        @(posedge clk); #1;
        check("jal.code_q", code_q, 32'h0800_0000);

        // Compressed encoding
        @(negedge clk);
        opcode = 7'b0000001;
        #1;
        check("cmp.code", code, 32'd0);
        check("cmp.fmt",  32'(fmt), 32'd0);
        check_comb("cmp", 7'b0000001);

        // custom-0: one-hot code, no format
        @(negedge clk);
        opcode = 7'b0001011;
        #1;
        check("cust0.code", code, 32'h0000_0004);
        check("cust0.fmt",  32'(fmt), 32'd0);
        check_comb("cust0", 7'b0001011);

        // Mid-cycle opcode change: comb follows, registers hold until the edge
        @(posedge clk); #1;
        @(negedge clk);
        opcode = 7'b1100011;
        #1;
        check_comb("mid", 7'b1100011);
        check("mid.code_q.hold", code_q, 32'h0000_0004);
        @(posedge clk); #1;
        check_regs("mid", 7'b1100011);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.code_q",    code_q,         32'd0);
        check("arst.fmt_q",     32'(fmt_q),     32'd0);
        check("arst.illegal_q", 32'(illegal_q), 32'd0);
        check_comb("arst", 7'b1100011);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst.rel.code_q", code_q, 32'd0);
        @(posedge clk); #1;
        check_regs("arst.reload", 7'b1100011);

        // Randomized opcodes, including a second change inside the cycle
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            opcode = 7'($urandom_range(0, 127));
            #1;
            check_comb("rnd.a", opcode);
            #2;
            op = 7'($urandom_range(0, 127));
            opcode = op;
            #1;
            check_comb("rnd.b", op);
            @(posedge clk); #1;
            check_regs("rnd", op);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
